// File: rtl/line_fill_ctrl.sv
// Cache line refill engine: fetches a full line critical-word-first,
// assembles it locally, then writes it into the line array in one cycle.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   miss_valid/miss_ready        miss request handshake
//   miss_addr, miss_way          missing byte address, one-hot victim way
//   mem_rd, mem_addr             word read request to main memory
//   mem_ack, mem_rdata           read data return
//   line_we                      single-cycle write strobe to line array
//   fill_way/set/tag/valid/data  line array write payload
//   fill_done                    one-cycle completion pulse
//   crit_data                    first (requested) word of the last fill
module line_fill_ctrl #(
    parameter int WORDS = 16,
    parameter int TAG_W = 25,
    parameter int WAYS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [31:0]           miss_addr,
    input  logic [WAYS-1:0]       miss_way,
    output logic                  mem_rd,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  line_we,
    output logic [WAYS-1:0]       fill_way,
    output logic                  fill_set,
    output logic [TAG_W-1:0]      fill_tag,
    output logic                  fill_valid,
    output logic [32*WORDS-1:0]   fill_data,
    output logic                  fill_done,
    output logic [31:0]           crit_data
);

    localparam int OFF_W = $clog2(WORDS);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  miss_ready_q, miss_ready_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic                  line_we_q, line_we_d;
    logic [WAYS-1:0]       fill_way_q, fill_way_d;
    logic                  fill_set_q, fill_set_d;
    logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [32*WORDS-1:0]   data_q, data_d;
    logic                  fill_done_q, fill_done_d;
    logic [31:0]           crit_q, crit_d;
    logic [OFF_W-1:0]      ptr_q, ptr_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;

    logic [OFF_W-1:0]      ptr_inc;
    logic [OFF_W-1:0]      miss_off;

    // Pointer wraps naturally in OFF_W bits, giving the critical-word-first
    // wrap from the last word back to word 0.
    assign ptr_inc  = ptr_q + 1'b1;
    assign miss_off = miss_addr[OFF_W+1:2];

    always_comb begin
        state_d      = state_q;
        miss_ready_d = miss_ready_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        line_we_d    = 1'b0;
        fill_way_d   = fill_way_q;
        fill_set_d   = fill_set_q;
        fill_tag_d   = fill_tag_q;
        fill_valid_d = 1'b0;
        data_d       = data_q;
        fill_done_d  = 1'b0;
        crit_d       = crit_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (miss_valid && miss_ready_q) begin
                    fill_tag_d   = miss_addr[31 -: TAG_W];
                    fill_set_d   = miss_addr[OFF_W+2];
                    fill_way_d   = miss_way;
                    ptr_d        = miss_off;
                    cnt_d        = '0;
                    miss_ready_d = 1'b0;
                    mem_rd_d     = 1'b1;
                    mem_addr_d   = {miss_addr[31 -: TAG_W],
                                    miss_addr[OFF_W+2],
                                    miss_off, 2'b00};
                    state_d      = RD;
                end
            end

            RD: begin
                if (mem_ack) begin
                    data_d[int'(ptr_q)*32 +: 32] = mem_rdata;
                    if (cnt_q == '0) begin
                        crit_d = mem_rdata;
                    end
                    ptr_d      = ptr_inc;
                    cnt_d      = cnt_q + 1'b1;
                    // Address advances with the ack so the request
                    // line never needs a bubble between words.
                    mem_addr_d = {fill_tag_q, fill_set_q,
                                  ptr_inc, 2'b00};
                    if (cnt_q == LAST) begin
                        mem_rd_d     = 1'b0;
                        line_we_d    = 1'b1;
                        fill_valid_d = 1'b1;
                        state_d      = WR;
                    end
                end
            end

            WR: begin
                fill_done_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                miss_ready_d = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                miss_ready_d = 1'b1;
                mem_rd_d     = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_ready_q <= 1'b1;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            line_we_q    <= 1'b0;
            fill_way_q   <= '0;
            fill_set_q   <= 1'b0;
            fill_tag_q   <= '0;
            fill_valid_q <= 1'b0;
            data_q       <= '0;
            fill_done_q  <= 1'b0;
            crit_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            miss_ready_q <= miss_ready_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            line_we_q    <= line_we_d;
            fill_way_q   <= fill_way_d;
            fill_set_q   <= fill_set_d;
            fill_tag_q   <= fill_tag_d;
            fill_valid_q <= fill_valid_d;
            data_q       <= data_d;
            fill_done_q  <= fill_done_d;
            crit_q       <= crit_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign miss_ready = miss_ready_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign line_we    = line_we_q;
    assign fill_way   = fill_way_q;
    assign fill_set   = fill_set_q;
    assign fill_tag   = fill_tag_q;
    assign fill_valid = fill_valid_q;
    assign fill_data  = data_q;
    assign fill_done  = fill_done_q;
    assign crit_data  = crit_q;

endmodule

// File: doc/line_fill_ctrl.md
Name: line_fill_ctrl

Overview:
- Refill engine directly upstream of the cache line storage: on a cache miss it fetches a full 16-word line from main memory, critical word first, and assembles it in a local buffer.
- When the line is complete it issues a single-cycle write of data, tag and valid into the chosen way and set of the line array, then signals completion to the miss handler.

Parameters:
- WORDS, 16, words per line; must be a power of two.
- TAG_W, 25, tag width; tag = addr[31:7].
- WAYS, 4, number of ways; fill_way is one-hot.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- miss_valid  input  1  miss request present.
- miss_ready  output  1  controller idle and able to accept a miss.
- miss_addr  input  32  byte address of missing word. addr[6] is the set index, addr[5:2] the word offset, addr[1:0] ignored.
- miss_way  input  WAYS  one-hot victim way, chosen by the replacement logic.
- mem_rd  output  1  word read request to main memory.
- mem_addr  output  32  word-aligned read address, bits [1:0] = 0.
- mem_ack  input  1  read data valid this cycle.
- mem_rdata  input  32  read data.
- line_we  output  1  one-cycle write strobe to the line array.
- fill_way  output  WAYS  one-hot way select for the write.
- fill_set  output  1  set index for the write.
- fill_tag  output  TAG_W  tag to store.
- fill_valid  output  1  valid bit to store; 1 during line_we.
- fill_data  output  32*WORDS  assembled line; word i at bits [32i+31:32i].
- fill_done  output  1  one-cycle completion pulse.
- crit_data  output  32  requested word; valid from the cycle its ack arrives until the next miss is accepted.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset values: state = IDLE, miss_ready = 1, mem_rd = 0, mem_addr = 0, line_we = 0, fill_way = 0, fill_set = 0, fill_tag = 0, fill_valid = 0, fill_data = 0, fill_done = 0, crit_data = 0, word counter = 0.
- IDLE:
  - miss_ready = 1.
  - On miss_valid & miss_ready, latch the tag, set, way and start offset s = miss_addr[5:2].
  - Set the pointer p = s and the counter = 0, then go to RD.
  - The latch is registered, so miss_ready drops in the following cycle.
- RD:
  - mem_rd = 1; mem_addr = {tag, set, p, 2'b00}.
  - mem_rd and mem_addr hold stable until mem_ack.
  - On mem_ack: buffer[p] <= mem_rdata. If counter == 0, crit_data <= mem_rdata. Then p <= (p + 1) mod 16 (15 wraps to 0) and counter++.
  - mem_rd stays high across back-to-back acks, so one word per cycle is possible.
  - mem_ack outside RD is ignored.
  - After the ack with counter == 15, mem_rd <= 0 and go to WR.
- WR:
  - Exactly one cycle with line_we = 1 and fill_valid = 1.
  - fill_way, fill_set, fill_tag and fill_data are driven from the latched values and the buffer.
  - Go to DONE.
- DONE: fill_done = 1 for one cycle, then IDLE. The earliest next miss is accepted in the cycle after DONE.
- Latency with zero-wait memory (ack in the cycle after mem_rd is seen): 16 RD cycles + WR + DONE = 18 cycles from acceptance to fill_done.
- fill_data, fill_tag, fill_set and fill_way hold their values after WR until the next miss is accepted. line_we is the only write qualifier for the line array.
- Reset in any state: return to IDLE on the next edge, with mem_rd = 0 and line_we = 0. A partially filled line is never written. An ack arriving in the reset cycle is dropped.
- miss_valid while busy is ignored; the requester holds it until miss_ready.
- An invalid (non-one-hot) miss_way is passed through unchanged; the requester is responsible for it.

Test Plan:
- Aligned fill, zero-wait memory: addr 0x0000_0080, way 4'b0001, rdata = 0xA000_0000 + word index -> mem_addr sequence 0x80, 0x84 .. 0xBC. line_we pulses 17 cycles after acceptance with fill_set = 0 and fill_tag = 1. Word i of fill_data = 0xA000_000i. fill_done one cycle later; crit_data = 0xA000_0000.
- Critical-word-first wrap: addr 0x0000_0074 (offset 13, set 1), way 4'b0100 -> mem_addr 0x74, 0x78, 0x7C, 0x40 .. 0x70. crit_data = word 13 after the first ack. The fill_data word order matches the aligned case; fill_set = 1.
- Memory stalls: a random 0–5 cycle gap before each ack -> mem_rd and mem_addr stay stable through every stall. Exactly 16 captures, exactly one line_we.
- Reset mid-fill: assert reset after the 7th ack -> next cycle state IDLE, mem_rd = 0, miss_ready = 1. No line_we pulse. A new miss then completes correctly.
- Busy rejection: a second miss_valid held during a fill -> it is ignored until DONE+1, then accepted with the new tag. Back-to-back fills give two line_we pulses with correct, distinct tags.
- Stray ack: mem_ack pulsed in IDLE and in WR -> no buffer change and no state change.
